// File: rtl/mul_div_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 op encoding, FSM states, iteration count.
package mul_div_unit_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mul_div_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } mul_div_state_e;

   localparam int MULDIV_ITER = 32;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
// Purely combinational, no latency, no flow control.
module mul_div_unit_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_in,
   input  logic         dvd_bit,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_out,
   output logic         q_bit
);

   logic [W:0] trial;

   // rem_in < divisor, so a successful subtraction always fits in W bits
   always_comb begin
      trial   = {rem_in, dvd_bit};
      q_bit   = (trial >= {1'b0, divisor});
      rem_out = q_bit ? (trial[W-1:0] - divisor) : trial[W-1:0];
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M mul/div: 32-cycle shift-add / restoring divide, result_valid at T+33 (T+1 for /0, overflow,
// and MUL-class ops when MUL_DIV_FAST_MUL_EN is defined); busy stalls the pipe from issue until DONE.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             kill,
   input  logic [2:0]       op,
   input  logic [XLEN-1:0]  src1,
   input  logic [XLEN-1:0]  src2,
   input  logic [TAG_W-1:0] tag_in,
   output logic             busy,
   output logic             result_valid,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] tag_out
);

   localparam int CNT_W = $clog2(MULDIV_ITER);

   mul_div_state_e    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   mul_div_op_e       op_q, op_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic              neg_q, neg_d;
   logic              neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [TAG_W-1:0]  tag_out_q, tag_out_d;

   logic              s1_signed, s2_signed, neg1, neg2, last_iter;
   logic [XLEN-1:0]   abs1, abs2, step_rem;
   logic              step_q;
   logic [2*XLEN-1:0] div_next;

   always_comb begin
      s1_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      s2_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      neg1      = s1_signed && src1[XLEN-1];
      neg2      = s2_signed && src2[XLEN-1];
      abs1      = neg1 ? -src1 : src1;
      abs2      = neg2 ? -src2 : src2;
      last_iter = (cnt_q == CNT_W'(MULDIV_ITER - 1));
   end

   // acc holds {partial remainder, dividend being shifted out / quotient being shifted in}
   mul_div_unit_div_step #(.W(XLEN)) u_div_step (
      .rem_in  (acc_q[2*XLEN-1:XLEN]),
      .dvd_bit (acc_q[XLEN-1]),
      .divisor (opnd_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   assign div_next = {step_rem, acc_q[XLEN-2:0], step_q};

`ifdef MUL_DIV_FAST_MUL_EN
   logic signed [2*XLEN-1:0] fast_a, fast_b, fast_p;

   always_comb begin
      fast_a = {{XLEN{neg1}}, src1};
      fast_b = {{XLEN{neg2}}, src2};
      fast_p = fast_a * fast_b;
   end
`else
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, mul_prod;

   // acc holds {running high sum, multiplier bits still to consume}
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
      mul_prod = neg_q ? -mul_next : mul_next;
   end
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_d         = op_q;
      tag_d        = tag_q;
      opnd_d       = opnd_q;
      acc_d        = acc_q;
      neg_d        = neg_q;
      neg_rem_d    = neg_rem_q;
      result_d     = result_q;
      tag_out_d    = tag_out_q;
      busy         = 1'b0;
      result_valid = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = start && !kill;
            if (start && !kill) begin
               op_d      = mul_div_op_e'(op);
               tag_d     = tag_in;
               neg_d     = neg1 ^ neg2;
               neg_rem_d = neg1;
               cnt_d     = '0;
               if (!op[2]) begin
`ifdef MUL_DIV_FAST_MUL_EN
                  result_d  = (op == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
                  tag_out_d = tag_in;
                  state_d   = ST_DONE;
`else
                  opnd_d  = abs1;
                  acc_d   = {{XLEN{1'b0}}, abs2};
                  state_d = ST_MUL;
`endif
               end else if (src2 == '0) begin
                  result_d  = op[1] ? src1 : '1;
                  tag_out_d = tag_in;
                  state_d   = ST_DONE;
               end else if (!op[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1)) begin
                  result_d  = op[1] ? '0 : src1;
                  tag_out_d = tag_in;
                  state_d   = ST_DONE;
               end else begin
                  opnd_d  = abs2;
                  acc_d   = {{XLEN{1'b0}}, abs1};
                  state_d = ST_DIV;
               end
            end
         end
`ifndef MUL_DIV_FAST_MUL_EN
         ST_MUL: begin
            busy = 1'b1;
            if (kill) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = mul_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_iter) begin
                  result_d  = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
                  tag_out_d = tag_q;
                  state_d   = ST_DONE;
               end
            end
         end
`endif
         ST_DIV: begin
            busy = 1'b1;
            if (kill) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = div_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_iter) begin
                  if (op_q[1]) begin
                     result_d = neg_rem_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
                  end else begin
                     result_d = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
                  end
                  tag_out_d = tag_q;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            result_valid = !kill;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (!rst) begin
         busy         = 1'b0;
         result_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= OP_MUL;
         tag_q     <= '0;
         opnd_q    <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         tag_out_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         tag_q     <= tag_d;
         opnd_q    <= opnd_d;
         acc_q     <= acc_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         tag_out_q <= tag_out_d;
      end
   end

   assign result  = result_q;
   assign tag_out = tag_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed RV32M results, latencies, kill and reset behaviour.
module tb_mul_div_unit;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
   localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

`ifdef MUL_DIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk, rst, start, kill;
   logic [2:0]  op;
   logic [31:0] src1, src2, result;
   logic [4:0]  tag_in, tag_out;
   logic        busy, result_valid;

   int compared   = 0;
   int mismatched = 0;

   mul_div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .kill         (kill),
      .op           (op),
      .src1         (src1),
      .src2         (src2),
      .tag_in       (tag_in),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result),
      .tag_out      (tag_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h, expected %h", name, obs, exp);
      end
   endtask

   // Called one time unit after a posedge; issues in this cycle (T) and returns in the cycle after DONE.
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input int lat, input logic [31:0] exp);
      int n;
      int busy_lo;
      bit seen;
      op = o; src1 = a; src2 = b; tag_in = t; start = 1'b1;
      #3;
      check({name, "_busy_issue"}, 32'(busy), 32'd1);
      check({name, "_no_stale_valid"}, 32'(result_valid), 32'd0);
      @(posedge clk); #1;
      start   = 1'b0;
      n       = 1;
      busy_lo = 0;
      seen    = 1'b0;
      while (!seen && n <= 40) begin
         #3;
         if (result_valid) begin
            seen = 1'b1;
         end else begin
            if (!busy) busy_lo++;
            n++;
            @(posedge clk); #1;
         end
      end
      check({name, "_latency"}, 32'(n), 32'(lat));
      check({name, "_busy_hold"}, 32'(busy_lo), 32'd0);
      check({name, "_result"}, result, exp);
      check({name, "_tag"}, 32'(tag_out), 32'(t));
      check({name, "_busy_done"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; kill = 1'b0; op = MUL;
      src1 = '0; src2 = '0; tag_in = '0;
      repeat (2) @(posedge clk);
      #1;
      #3;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_valid", 32'(result_valid), 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_tag", 32'(tag_out), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      step();

      run_op("mul_7_m3",     MUL,    32'd7,         32'hFFFFFFFD, 5'd5, MUL_LAT, 32'hFFFFFFEB);
      run_op("mulh_min_sq",  MULH,   32'h80000000,  32'h80000000, 5'd1, MUL_LAT, 32'h40000000);
      run_op("mulhu_max_sq", MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 5'd2, MUL_LAT, 32'hFFFFFFFE);
      run_op("mulhsu_m1_2",  MULHSU, 32'hFFFFFFFF,  32'd2,        5'd3, MUL_LAT, 32'hFFFFFFFF);
      run_op("div_m7_2",     DIV,    32'hFFFFFFF9,  32'd2,        5'd4, DIV_LAT, 32'hFFFFFFFD);
      run_op("rem_m7_2",     REM,    32'hFFFFFFF9,  32'd2,        5'd6, DIV_LAT, 32'hFFFFFFFF);
      run_op("divu_100_7",   DIVU,   32'd100,       32'd7,        5'd7, DIV_LAT, 32'd14);
      run_op("remu_100_7",   REMU,   32'd100,       32'd7,        5'd8, DIV_LAT, 32'd2);
      run_op("divu_5_0",     DIVU,   32'd5,         32'd0,        5'd9, 1,       32'hFFFFFFFF);
      run_op("rem_5_0",      REM,    32'd5,         32'd0,        5'd10, 1,      32'd5);

      // kill a DIV at T+10: no pulse, result/tag keep the previous op's values
      op = DIV; src1 = 32'd100; src2 = 32'd7; tag_in = 5'd11; start = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      kill = 1'b1;
      #3;
      check("kill_t10_valid", 32'(result_valid), 32'd0);
      check("kill_t10_busy", 32'(busy), 32'd1);
      step();
      kill = 1'b0;
      #3;
      check("kill_t11_busy", 32'(busy), 32'd0);
      check("kill_t11_valid", 32'(result_valid), 32'd0);
      check("kill_t11_result", result, 32'd5);
      check("kill_t11_tag", 32'(tag_out), 32'd10);
      step();
      run_op("mul_after_kill", MUL, 32'd6, 32'd7, 5'd12, MUL_LAT, 32'd42);

      // reset in the middle of a MUL; start during reset must be ignored
      op = MUL; src1 = 32'd3; src2 = 32'd4; tag_in = 5'd13; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      rst = 1'b0; start = 1'b1; op = DIVU; src1 = 32'd9; src2 = 32'd3;
      #3;
      check("rst_t5_busy", 32'(busy), 32'd0);
      check("rst_t5_valid", 32'(result_valid), 32'd0);
      step();
      #3;
      check("rst_t6_busy", 32'(busy), 32'd0);
      check("rst_t6_valid", 32'(result_valid), 32'd0);
      check("rst_t6_result", result, 32'd0);
      check("rst_t6_tag", 32'(tag_out), 32'd0);
      step();
      rst = 1'b1; start = 1'b0;
      #3;
      check("rst_release_busy", 32'(busy), 32'd0);
      step();
      run_op("divu_9_3", DIVU, 32'd9, 32'd3, 5'd14, DIV_LAT, 32'd3);
      run_op("remu_9_4", REMU, 32'd9, 32'd4, 5'd15, DIV_LAT, 32'd1);

      run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 5'd16, 1, 32'h80000000);
      run_op("rem_ovf", REM, 32'h80000000, 32'hFFFFFFFF, 5'd17, 1, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
